alu_ctrl_unit: RTL and testbench

Registered, handshaked successor to the combinational ALU decoder. It sits between the ID and EX pipeline stages. It decodes a widened 3-bit `aluop` plus the 6-bit `funct` into a 4-bit ALU control word, and flags illegal encodings. It also sequences the multi-cycle multiply/divide unit, stalling dependent HI/LO reads until the operation completes.

---
 rtl/alu_ctrl_unit.sv | 145 ++++++++++++++
 tb/tb_alu_ctrl_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_unit.sv
// ALU control decoder with mul/div sequencer; 1-cycle decode latency, single output register.
// in_ready drops when the held result is not consumed, or when a mul/div/mfhi/mflo arrives while the unit is busy.
// Build option ALU_CTRL_DIV_EN: enables div/divu decode and the DIV_LAT counter load.
module alu_ctrl_unit #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] aluop,
    input  logic [5:0] funct,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] aluctl,
    output logic       illegal,
    output logic       md_start,
    output logic [1:0] md_op,
    output logic       md_busy,
    output logic       md_done
);

    typedef enum logic {IDLE, BUSY} md_state_t;

    // Out-of-range latencies block launches rather than silently wrapping the counter.
    localparam bit LAT_LEGAL = (MUL_LAT >= 2) && (MUL_LAT <= 255) &&
                               (DIV_LAT >= 2) && (DIV_LAT <= 255);
    localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 1);
`ifdef ALU_CTRL_DIV_EN
    localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);
`endif

    md_state_t  md_state;
    logic [7:0] md_cnt;
    logic [7:0] cnt_load;
    logic [3:0] dec_ctl;
    logic       dec_ill;
    logic       dec_md;
    logic       dec_hilo;
    logic       hold;
    logic       accept;
    logic       launch;

    always_comb begin
        dec_ctl  = 4'b0000;
        dec_ill  = 1'b0;
        dec_md   = 1'b0;
        dec_hilo = 1'b0;
        case (aluop)
            3'b000: dec_ctl = 4'b0010;
            3'b001: dec_ctl = 4'b0110;
            3'b011: dec_ctl = 4'b0000;
            3'b100: dec_ctl = 4'b0001;
            3'b101: dec_ctl = 4'b0111;
            3'b110: dec_ctl = 4'b1001;
            3'b111: dec_ctl = 4'b0011;
            3'b010: begin
                case (funct)
                    6'b100000, 6'b100001: dec_ctl = 4'b0010;
                    6'b100010, 6'b100011: dec_ctl = 4'b0110;
                    6'b100100: dec_ctl = 4'b0000;
                    6'b100101: dec_ctl = 4'b0001;
                    6'b100110: dec_ctl = 4'b0011;
                    6'b100111: dec_ctl = 4'b1100;
                    6'b101010: dec_ctl = 4'b0111;
                    6'b101011: dec_ctl = 4'b1001;
                    6'b000000: dec_ctl = 4'b0100;
                    6'b000010: dec_ctl = 4'b0101;
                    6'b000011: dec_ctl = 4'b1101;
                    6'b010000: begin dec_ctl = 4'b1010; dec_hilo = 1'b1; end
                    6'b010010: begin dec_ctl = 4'b1011; dec_hilo = 1'b1; end
                    6'b011000, 6'b011001: begin dec_ctl = 4'b1110; dec_md = 1'b1; end
`ifdef ALU_CTRL_DIV_EN
                    6'b011010, 6'b011011: begin dec_ctl = 4'b1110; dec_md = 1'b1; end
`endif
                    default: begin dec_ctl = 4'b1111; dec_ill = 1'b1; end
                endcase
            end
        endcase
    end

`ifdef ALU_CTRL_DIV_EN
    assign cnt_load = funct[1] ? DIV_CNT : MUL_CNT;
`else
    assign cnt_load = MUL_CNT;
`endif

    // md_busy stays high through the md_done cycle, so dependents wait one more cycle.
    assign hold     = md_busy & (dec_md | dec_hilo);
    assign in_ready = (!out_valid | out_ready) & !hold;
    assign accept   = in_valid & in_ready;
    assign launch   = accept & dec_md & LAT_LEGAL;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            aluctl    <= 4'b0000;
            illegal   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            aluctl    <= dec_ctl;
            illegal   <= dec_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_state <= IDLE;
            md_cnt   <= 8'd0;
            md_op    <= 2'b00;
            md_start <= 1'b0;
            md_busy  <= 1'b0;
            md_done  <= 1'b0;
        end else begin
            md_start <= 1'b0;
            case (md_state)
                IDLE: begin
                    md_done <= 1'b0;
                    if (launch) begin
                        md_state <= BUSY;
                        md_cnt   <= cnt_load;
                        md_op    <= funct[1:0];
                        md_start <= 1'b1;
                        md_busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (md_cnt == 8'd0) begin
                        md_state <= IDLE;
                        md_busy  <= 1'b0;
                        md_done  <= 1'b0;
                    end else begin
                        md_cnt  <= md_cnt - 8'd1;
                        md_done <= (md_cnt == 8'd1);
                    end
                end
                default: md_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Randomized plus directed bench for alu_ctrl_unit against a transaction-level reference model.
module tb_alu_ctrl_unit;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] aluop = 3'd0;
    logic [5:0] funct = 6'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] aluctl;
    logic       illegal;
    logic       md_start;
    logic [1:0] md_op;
    logic       md_busy;
    logic       md_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_ctrl_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
        .aluctl(aluctl), .illegal(illegal), .md_start(md_start), .md_op(md_op),
        .md_busy(md_busy), .md_done(md_done)
    );

    // Reference state: m_left counts remaining busy cycles including the current one.
    bit         m_ov, m_ill, m_start;
    logic [3:0] m_ctl;
    logic [1:0] m_op;
    int         m_left;

    localparam logic [3:0] NONR [8] = '{4'b0010, 4'b0110, 4'b1111, 4'b0000,
                                        4'b0001, 4'b0111, 4'b1001, 4'b0011};

    function automatic void ref_decode(input logic [2:0] a, input logic [5:0] f,
                                       output logic [3:0] ctl, output bit ill,
                                       output bit md, output bit hilo);
        int n;
        bit div_ok;
`ifdef ALU_CTRL_DIV_EN
        div_ok = 1'b1;
`else
        div_ok = 1'b0;
`endif
        n = int'(f);
        ill = 1'b0; md = 1'b0; hilo = 1'b0;
        ctl = NONR[a];
        if (a == 3'd2) begin
            case (n)
                32, 33: ctl = 4'd2;
                34, 35: ctl = 4'd6;
                36: ctl = 4'd0;
                37: ctl = 4'd1;
                38: ctl = 4'd3;
                39: ctl = 4'd12;
                42: ctl = 4'd7;
                43: ctl = 4'd9;
                0:  ctl = 4'd4;
                2:  ctl = 4'd5;
                3:  ctl = 4'd13;
                16: begin ctl = 4'd10; hilo = 1'b1; end
                18: begin ctl = 4'd11; hilo = 1'b1; end
                default: begin ctl = 4'd15; ill = 1'b1; end
            endcase
            if (n == 24 || n == 25 || ((n == 26 || n == 27) && div_ok)) begin
                ctl = 4'd14; ill = 1'b0; md = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ov = 0; m_ill = 0; m_start = 0; m_ctl = 4'd0; m_op = 2'd0; m_left = 0;
    endtask

    task automatic check_outs();
        chk("out_valid", 8'(out_valid), 8'(m_ov));
        chk("aluctl",    8'(aluctl),    8'(m_ctl));
        chk("illegal",   8'(illegal),   8'(m_ill));
        chk("md_start",  8'(md_start),  8'(m_start));
        chk("md_op",     8'(md_op),     8'(m_op));
        chk("md_busy",   8'(md_busy),   8'(m_left > 0));
        chk("md_done",   8'(md_done),   8'(m_left == 1));
    endtask

    // One clock cycle: drive after negedge, check in_ready, advance model at posedge, check outputs.
    task automatic step(input bit v, input logic [2:0] a, input logic [5:0] f,
                        input bit r, output bit dut_acc);
        logic [3:0] ctl;
        bit ill, md, hilo, busy, rdy, acc;
        @(negedge clk);
        in_valid = v; aluop = a; funct = f; out_ready = r;
        #1;
        ref_decode(a, f, ctl, ill, md, hilo);
        busy = (m_left > 0);
        rdy  = (!m_ov || r) && !(busy && (md || hilo));
        chk("in_ready", 8'(in_ready), 8'(rdy));
        dut_acc = v && in_ready;
        acc = v && rdy;
        @(posedge clk);
        m_start = 0;
        if (m_left > 0) m_left--;
        if (acc && md && !busy) begin
            m_left  = (f[1] ? DIV_LAT : MUL_LAT);
            m_start = 1;
            m_op    = f[1:0];
        end
        if (acc) begin
            m_ov = 1; m_ctl = ctl; m_ill = ill;
        end else if (r) begin
            m_ov = 0;
        end
        #1;
        check_outs();
    endtask

    logic [5:0] pool [16] = '{6'b100000, 6'b100001, 6'b100010, 6'b100100, 6'b100111,
                              6'b101010, 6'b101011, 6'b000000, 6'b000011, 6'b010000,
                              6'b010010, 6'b011000, 6'b011001, 6'b011010, 6'b011011,
                              6'b111111};

    initial begin
        bit acc;
        int n;
        logic [5:0] long_op;
        logic [5:0] fr;
        logic [2:0] ar;
`ifdef ALU_CTRL_DIV_EN
        long_op = 6'b011011;
`else
        long_op = 6'b011000;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        chk("reset_in_ready", 8'(in_ready), 8'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Non-R-type stream.
        step(1, 3'b000, 6'd0, 1, acc);
        step(1, 3'b001, 6'd0, 1, acc);
        step(1, 3'b011, 6'd0, 1, acc);
        step(1, 3'b111, 6'd0, 1, acc);
        // R-type, including an illegal funct.
        step(1, 3'b010, 6'b100111, 1, acc);
        step(1, 3'b010, 6'b101011, 1, acc);
        step(1, 3'b010, 6'b000011, 1, acc);
        step(1, 3'b010, 6'b111111, 1, acc);
        chk("illegal_funct", 8'(illegal), 8'd1);

        // mult then dependent mflo, counting stalled attempts.
        step(1, 3'b010, 6'b011000, 1, acc);
        n = 0;
        acc = 0;
        while (!acc && n < 20) begin
            step(1, 3'b010, 6'b010010, 1, acc);
            if (!acc) n++;
        end
        chk("mflo_stall_cycles", 8'(n), 8'(MUL_LAT));
        chk("mflo_aluctl", 8'(aluctl), 8'b1011);
        step(0, 3'b000, 6'd0, 1, acc);

        // Long op, then a non-dependent add and a blocked second mult during BUSY.
        step(1, 3'b010, long_op, 1, acc);
        step(1, 3'b010, 6'b100000, 1, acc);
        chk("add_in_busy", 8'(aluctl), 8'b0010);
        step(1, 3'b010, 6'b011000, 1, acc);
        chk("mult_blocked", 8'(acc), 8'd0);
        repeat (DIV_LAT + 2) step(0, 3'b000, 6'd0, 1, acc);

        // Backpressure holds slt stable.
        step(1, 3'b101, 6'd0, 1, acc);
        repeat (3) step(1, 3'b000, 6'd0, 0, acc);
        chk("held_aluctl", 8'(aluctl), 8'b0111);
        step(1, 3'b000, 6'd0, 1, acc);
        chk("release_accept", 8'(acc), 8'd1);

        // Divide encodings (illegal in the default build).
        step(1, 3'b010, 6'b011010, 1, acc);
        repeat (DIV_LAT + 1) step(0, 3'b000, 6'd0, 1, acc);

        // Reset two cycles into a long op.
        step(1, 3'b010, long_op, 1, acc);
        step(0, 3'b000, 6'd0, 1, acc);
        step(0, 3'b000, 6'd0, 1, acc);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (DIV_LAT + 2) step(0, 3'b000, 6'd0, 1, acc);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            ar = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            fr = ($urandom_range(0, 9) == 0) ? 6'($urandom) : pool[$urandom_range(0, 15)];
            step(1'($urandom_range(0, 3) != 0), ar, fr, 1'($urandom_range(0, 3) != 0), acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
